// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, FSM state type and bit-offset helper for display_pager
package display_pkg;

  localparam int         SEG_W      = 5;
  localparam logic [4:0] BLANK_CODE = 5'b10000;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } pager_state_e;

  // Flattened digit index of page p, digit d; nibble offsets are 4x this.
  function automatic int page_idx(input int p, input int d, input int digits);
    return p * digits + d;
  endfunction

endpackage

// File: rtl/pager_timebase.sv
// rtl/pager_timebase.sv - millisecond tick and blink phase generator for display_pager
module pager_timebase
  import display_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic clk,
  input  logic n_rst,
  output logic ms_tick,
  output logic blink_on
);

  localparam int MS_CYC = CLK_FREQ / 1000;
  localparam int HALF   = CLK_FREQ / (2 * BLINK_HZ);
  localparam int MS_W   = $clog2(MS_CYC + 1);
  localparam int BL_W   = $clog2(HALF + 1);

  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
  logic            ms_tick_q, ms_tick_d;
  logic            blink_q, blink_d;

  // The tick is registered so the first pulse lands MS_CYC cycles after reset release.
  always_comb begin
    ms_tick_d = (ms_cnt_q == MS_W'(MS_CYC - 1));
    ms_cnt_d  = ms_tick_d ? '0 : ms_cnt_q + MS_W'(1);
    bl_cnt_d  = (bl_cnt_q == BL_W'(HALF - 1)) ? '0 : bl_cnt_q + BL_W'(1);
    blink_d   = (bl_cnt_q == BL_W'(HALF - 1)) ? ~blink_q : blink_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ms_cnt_q  <= '0;
      bl_cnt_q  <= '0;
      ms_tick_q <= 1'b0;
      blink_q   <= 1'b1;
    end else begin
      ms_cnt_q  <= ms_cnt_d;
      bl_cnt_q  <= bl_cnt_d;
      ms_tick_q <= ms_tick_d;
      blink_q   <= blink_d;
    end
  end

  assign ms_tick  = ms_tick_q;
  assign blink_on = blink_q;

endmodule

// File: rtl/display_pager.sv
// rtl/display_pager.sv - multi-page digit selector with manual/auto rotation, blink and freeze
module display_pager
  import display_pkg::*;
#(
  parameter int PAGES    = 4,
  parameter int DIGITS   = 6,
  parameter int CLK_FREQ = 50_000_000,
  parameter int DWELL_MS = 2000,
  parameter int BLINK_HZ = 2,
  localparam int PW      = $clog2(PAGES)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [PAGES*DIGITS*4-1:0]  page_data,
  input  logic [PAGES*DIGITS-1:0]    page_ext,
  input  logic [PAGES*DIGITS-1:0]    page_blink,
  input  logic [PAGES-1:0]           page_valid,
  input  logic [PW-1:0]              sel,
  input  logic                       auto_en,
  input  logic                       freeze,
  output logic [DIGITS*SEG_W-1:0]    seg_data,
  output logic [PW-1:0]              cur_page,
  output logic                       page_tick
);

  localparam int DW_W = $clog2(DWELL_MS + 1);

  logic ms_tick, blink_on;

  pager_timebase #(
    .CLK_FREQ (CLK_FREQ),
    .BLINK_HZ (BLINK_HZ)
  ) u_timebase (
    .clk      (clk),
    .n_rst    (n_rst),
    .ms_tick  (ms_tick),
    .blink_on (blink_on)
  );

  pager_state_e              state_q, state_d;
  logic [PW-1:0]             cur_q, cur_d;
  logic [DW_W-1:0]           dwell_q, dwell_d;
  logic [DIGITS*SEG_W-1:0]   seg_q, seg_d, seg_live;
  logic                      tick_q, tick_d;
  logic [PW-1:0]             next_page;
  logic                      next_found;
  logic                      expire;

  // First valid page strictly after cur_q, wrapping; holds when none is found.
  always_comb begin
    next_page  = cur_q;
    next_found = 1'b0;
    for (int k = 1; k < PAGES; k++) begin
      if (!next_found && page_valid[(int'(cur_q) + k) % PAGES]) begin
        next_page  = PW'((int'(cur_q) + k) % PAGES);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    seg_live = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (page_blink[page_idx(int'(cur_q), d, DIGITS)] && !blink_on)
        seg_live[d*SEG_W +: SEG_W] = BLANK_CODE;
      else
        seg_live[d*SEG_W +: SEG_W] = {page_ext[page_idx(int'(cur_q), d, DIGITS)],
                                      page_data[page_idx(int'(cur_q), d, DIGITS)*4 +: 4]};
    end
  end

  // A dwell parked at DWELL_MS (expiry hit while frozen) fires on the first unfrozen cycle.
  always_comb begin
    state_d = auto_en ? AUTO : MANUAL;
    cur_d   = cur_q;
    dwell_d = dwell_q;
    seg_d   = seg_q;
    tick_d  = 1'b0;
    expire  = (dwell_q == DW_W'(DWELL_MS)) ||
              (ms_tick && (dwell_q == DW_W'(DWELL_MS - 1)));
    if (freeze) begin
      if (state_d == AUTO && ms_tick && (dwell_q == DW_W'(DWELL_MS - 1)))
        dwell_d = DW_W'(DWELL_MS);
    end else begin
      seg_d = seg_live;
      if (state_d == MANUAL) begin
        dwell_d = '0;
        if (int'(sel) < PAGES)
          cur_d = sel;
      end else if (state_q == MANUAL) begin
        dwell_d = '0;
      end else if (expire) begin
        dwell_d = '0;
        cur_d   = next_page;
      end else if (ms_tick) begin
        dwell_d = dwell_q + DW_W'(1);
      end
      tick_d = (cur_d != cur_q);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= MANUAL;
      cur_q   <= '0;
      dwell_q <= '0;
      seg_q   <= {DIGITS{BLANK_CODE}};
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dwell_q <= dwell_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
    end
  end

  assign seg_data  = seg_q;
  assign cur_page  = cur_q;
  assign page_tick = tick_q;

endmodule

// File: tb/tb_display_pager.sv
// tb/tb_display_pager.sv - randomized scoreboard bench for display_pager against a behavioural model
module tb_display_pager;

  localparam int P  = 4;
  localparam int D  = 6;
  localparam int DW = 3;
  localparam int MS = 4;
  localparam int HB = 4;

  logic          clk;
  logic          n_rst;
  logic [P*D*4-1:0] page_data;
  logic [P*D-1:0]   page_ext, page_blink;
  logic [P-1:0]     page_valid;
  logic [1:0]       sel;
  logic             auto_en, freeze;
  logic [D*5-1:0]   seg_data;
  logic [1:0]       cur_page;
  logic             page_tick;

  logic [5*D*4-1:0] data5;
  logic [5*D-1:0]   ext5, blink5;
  logic [4:0]       valid5;
  logic [2:0]       sel5;
  logic             auto5, freeze5;
  logic [D*5-1:0]   seg5;
  logic [2:0]       cur5;
  logic             tick5;

  display_pager #(.PAGES(P), .DIGITS(D), .CLK_FREQ(4000), .DWELL_MS(DW), .BLINK_HZ(500)) dut (
    .clk(clk), .n_rst(n_rst), .page_data(page_data), .page_ext(page_ext),
    .page_blink(page_blink), .page_valid(page_valid), .sel(sel), .auto_en(auto_en),
    .freeze(freeze), .seg_data(seg_data), .cur_page(cur_page), .page_tick(page_tick)
  );

  display_pager #(.PAGES(5), .DIGITS(D), .CLK_FREQ(4000), .DWELL_MS(DW), .BLINK_HZ(500)) dut5 (
    .clk(clk), .n_rst(n_rst), .page_data(data5), .page_ext(ext5),
    .page_blink(blink5), .page_valid(valid5), .sel(sel5), .auto_en(auto5),
    .freeze(freeze5), .seg_data(seg5), .cur_page(cur5), .page_tick(tick5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cur;
    bit          tick;
    logic [D*5-1:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: cycles since reset release, ms ticks counted toward the dwell.
  int             m_n, m_cur, m_dwell;
  bit             m_tick, m_prev_auto;
  logic [D*5-1:0] m_seg;

  function automatic int next_valid(input int cur, input logic [P-1:0] v);
    for (int k = 1; k < P; k++)
      if (v[(cur + k) % P]) return (cur + k) % P;
    return cur;
  endfunction

  task automatic model_reset();
    m_n = 0; m_cur = 0; m_dwell = 0; m_tick = 0; m_prev_auto = 0;
    m_seg = {D{5'b10000}};
  endtask

  task automatic model_step();
    exp_t e;
    bit tk, bon;
    int old, idx;
    logic [D*5-1:0] segn;
    if (!n_rst) begin
      model_reset();
    end else begin
      tk  = (m_n > 0) && (m_n % MS == 0);
      bon = ((m_n / HB) % 2) == 0;
      for (int d = 0; d < D; d++) begin
        idx = m_cur * D + d;
        segn[d*5 +: 5] = (page_blink[idx] && !bon) ? 5'b10000
                                                  : {page_ext[idx], page_data[idx*4 +: 4]};
      end
      old    = m_cur;
      m_tick = 0;
      if (freeze) begin
        if (auto_en && tk && m_dwell == DW - 1) m_dwell = DW;
      end else begin
        m_seg = segn;
        if (!auto_en) begin
          m_dwell = 0;
          m_cur   = int'(sel);
        end else if (!m_prev_auto) begin
          m_dwell = 0;
        end else begin
          if (tk) m_dwell++;
          if (m_dwell >= DW) begin
            m_dwell = 0;
            m_cur   = next_valid(m_cur, page_valid);
          end
        end
        m_tick = (m_cur != old);
      end
      m_prev_auto = auto_en;
      m_n++;
    end
    e.cur = m_cur; e.tick = m_tick; e.seg = m_seg;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cur_page", 64'(cur_page), 64'(e.cur));
      check("page_tick", 64'(page_tick), 64'(e.tick));
      check("seg_data", 64'(seg_data), 64'(e.seg));
    end
  end

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      page_data = {$urandom, $urandom, $urandom};
      page_ext  = 24'($urandom);
      case (mode)
        1: page_blink = 24'($urandom);
        2: begin
          page_blink = 24'($urandom);
          freeze     = ($urandom_range(0, 3) == 0);
          sel        = 2'($urandom);
          page_valid = 4'($urandom);
          if ($urandom_range(0, 15) == 0) auto_en = ~auto_en;
        end
        default: ;
      endcase
      model_step();
      @(negedge clk);
    end
  endtask

  initial begin
    int wait_cnt;
    n_rst = 0; page_data = '0; page_ext = '0; page_blink = '0; page_valid = '0;
    sel = 0; auto_en = 0; freeze = 0;
    data5 = {$urandom, $urandom, $urandom, $urandom};
    ext5 = 30'($urandom); blink5 = '0; valid5 = 5'h1f; sel5 = 0; auto5 = 0; freeze5 = 0;
    model_reset();
    @(negedge clk);
    run(2, 0);
    n_rst = 1; sel = 2;
    run(4, 0);
    auto_en = 1; page_valid = 4'hf;
    run(60, 0);
    page_valid = 4'b1001;
    run(40, 0);
    page_valid = 4'b0000;
    run(30, 0);
    page_valid = 4'hf;
    run(40, 1);
    run(120, 2);
    freeze = 0; auto_en = 1; page_valid = 4'hf; page_blink = '0;
    run(21, 0);
    n_rst = 0;
    model_step();
    #1;
    check("rst_cur_now", 64'(cur_page), 64'd0);
    check("rst_seg_now", 64'(seg_data), 64'({D{5'b10000}}));
    @(negedge clk);
    run(1, 0);
    n_rst = 1;
    run(40, 1);
    sel5 = 3;
    repeat (3) @(negedge clk);
    check("p5_cur_sel3", 64'(cur5), 64'd3);
    sel5 = 4;
    repeat (3) @(negedge clk);
    check("p5_cur_sel4", 64'(cur5), 64'd4);
    check("p5_seg_d0", 64'(seg5[4:0]), 64'({ext5[24], data5[99:96]}));
    sel5 = 7;
    repeat (3) @(negedge clk);
    check("p5_cur_sel7", 64'(cur5), 64'd4);
    check("p5_tick_sel7", 64'(tick5), 64'd0);
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_pager.md
# display_pager

Parametrised successor to the four-mode seven-segment display multiplexer. It selects one of `PAGES` pages of `DIGITS` hex/extended-character digits and drives the `{ext, nibble}` bus consumed by `display_drv`. Pages are chosen manually from switches or rotated automatically on a millisecond dwell timer that skips disabled pages. It adds per-digit blinking, a freeze/hold input and a page-change strobe. It sits between the sensor/counter blocks and `display_drv` in the top level.

## Interface
Parameters:
- `PAGES`, 4: number of pages, 2..16.
- `DIGITS`, 6: digits per page.
- `CLK_FREQ`, 50_000_000: `clk` frequency in Hz; must be divisible by 1000 and by 2*`BLINK_HZ`.
- `DWELL_MS`, 2000: auto-rotate dwell per page, in ms; ≥1.
- `BLINK_HZ`, 2: blink rate; half period is `CLK_FREQ/(2*BLINK_HZ)` cycles.

Ports (`PW` = clog2(`PAGES`)):
- `clk` in 1: single clock. All logic is synchronous to it.
- `n_rst` in 1: asynchronous, active-low reset.
- `page_data` in `PAGES*DIGITS*4`: nibble for page p, digit d at `[(p*DIGITS+d)*4 +: 4]`.
- `page_ext` in `PAGES*DIGITS`: extended-character-set enable per digit, bit `p*DIGITS+d`.
- `page_blink` in `PAGES*DIGITS`: blink enable per digit, same indexing.
- `page_valid` in `PAGES`: page participates in auto-rotation.
- `sel` in `PW`: manual page select.
- `auto_en` in 1: 1 = auto-rotate, 0 = manual.
- `freeze` in 1: hold the displayed output (level).
- `seg_data` out `DIGITS*5`: digit d at `[d*5 +: 5]` = `{ext, nibble}`.
- `cur_page` out `PW`: currently selected page.
- `page_tick` out 1: one-cycle pulse when `cur_page` changes.

## Operation
- Timebase:
  - `ms_tick` pulses once every `CLK_FREQ/1000` cycles.
  - `blink_on` toggles every `CLK_FREQ/(2*BLINK_HZ)` cycles.
- FSM states are MANUAL and AUTO. AUTO is selected when `auto_en`=1.
- MANUAL:
  - `cur_page` ← `sel` each cycle.
  - If `sel` ≥ `PAGES`, `cur_page` holds its value.
  - The dwell counter is held at 0.
- AUTO:
  - The dwell counter counts `ms_tick`s. At `DWELL_MS` it clears and `cur_page` advances to the next page after `cur_page` with `page_valid`=1, searching upward with wrap to 0.
  - If no other page is valid, `cur_page` holds.
  - If no page is valid at all, `cur_page` holds and `page_tick` does not pulse.
- MANUAL→AUTO: the dwell counter restarts at 0 from the current page.
- AUTO→MANUAL: `cur_page` follows `sel` from the next cycle.
- Invalid current page: if the current page becomes invalid while in AUTO, it is left at the next dwell expiry. There is no immediate jump.
- Digit output:
  - If `page_blink`=1 and `blink_on`=0, the digit is `BLANK_CODE` = `{1'b1,4'h0}`.
  - Otherwise the digit is `{page_ext, page_data}` of `cur_page`.
- `freeze`=1 holds:
  - `seg_data`, `cur_page` and the dwell counter.
  - `page_tick` stays 0.
  - The timebase and `blink_on` keep running.
  - `sel` changes are ignored while frozen and applied on the first cycle after release.
- Simultaneous events:
  - Dwell expiry and `auto_en` falling in the same cycle: the manual `sel` wins.
  - `freeze` rising in the same cycle as expiry: the freeze wins and the dwell counter holds at `DWELL_MS`. The advance occurs on the first unfrozen cycle.

## Timing
- Reset values: `cur_page`=0, `seg_data` = all digits `BLANK_CODE`, `page_tick`=0, dwell=0, `blink_on`=1, timebase counters=0.
- `cur_page` is registered. It updates 1 cycle after a `sel` change (MANUAL) or after the expiring `ms_tick` (AUTO).
- `page_tick` is asserted in the same cycle `cur_page` shows its new value.
- `seg_data` is registered and reflects `cur_page`, the page inputs and `blink_on` with 1 cycle latency. Total latency from `sel` to `seg_data` is 2 cycles.
- Reset asserted mid-operation returns everything to the reset values immediately. After release, the first `ms_tick` occurs `CLK_FREQ/1000` cycles later.

## Structure
- Package `display_pkg` holds:
  - `BLANK_CODE`.
  - The digit field width (5).
  - A `page_idx` function computing flattened bit offsets.
  - The FSM state enum {MANUAL, AUTO}.
- Sub-module `pager_timebase` (params `CLK_FREQ`, `BLINK_HZ`) produces `ms_tick` and `blink_on`.
- The next-valid-page search is a combinational priority loop inside `display_pager`.

## Test plan
Bench parameters: `PAGES`=4, `DIGITS`=6, `CLK_FREQ`=4000, `DWELL_MS`=3, `BLINK_HZ`=500 (ms = 4 cycles, blink half period = 4 cycles).
- Reset, then manual `sel`=2 → `cur_page`=2 after 1 cycle, `page_tick` 1 pulse, `seg_data` = page 2 digits 2 cycles after `sel`.
- AUTO, all pages valid → pages 0→1→2→3→0 every 12 cycles, with one `page_tick` per change.
- AUTO, `page_valid`=4'b1001 → pages 0→3→0. With `page_valid`=0, `cur_page` holds and there is no tick.
- `page_blink` on digit 0 of the current page → digit 0 alternates `{ext,data}`/`5'b10000` every 4 cycles; other digits are steady.
- `freeze` high across a dwell expiry → `seg_data` and `cur_page` are constant. On release, the advance occurs on the next cycle.
- `n_rst` low mid-rotation → `cur_page`=0, all digits `BLANK_CODE` immediately. A `sel`≥4 (wider `PW` variant, `PAGES`=5, `sel`=7) leaves `cur_page` held.
